// File: rtl/sm3_msg_arb.sv
// Message-granular two-requester arbiter feeding sm3_pad_core: one owner per message, held until
// the padded message drains, with a registered forward stage, byte-enable format check and drain timeout.
module sm3_msg_arb #(
  parameter  int INPT_DW   = 32,
  parameter  int DRAIN_TMO = 1024,
  localparam int BW        = INPT_DW / 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_vld_i,
  input  logic [INPT_DW-1:0] req0_d_i,
  input  logic [BW-1:0]      req0_vld_byte_i,
  input  logic               req0_lst_i,
  output logic               req0_rdy_o,
  input  logic               req1_vld_i,
  input  logic [INPT_DW-1:0] req1_d_i,
  input  logic [BW-1:0]      req1_vld_byte_i,
  input  logic               req1_lst_i,
  output logic               req1_rdy_o,
  output logic               msg_inpt_vld_o,
  output logic [INPT_DW-1:0] msg_inpt_d_o,
  output logic [BW-1:0]      msg_inpt_vld_byte_o,
  output logic               msg_inpt_lst_o,
  input  logic               pad_otpt_lst_i,
  output logic               own_id_o,
  output logic               busy_o,
  output logic [60:0]        msg_byte_cnt_o,
  output logic [15:0]        msg_cnt0_o,
  output logic [15:0]        msg_cnt1_o,
  output logic               err_fmt_o,
  output logic               err_tmo_o
);

  localparam int TW = (DRAIN_TMO > 1) ? $clog2(DRAIN_TMO) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t             state_q, state_d;
  logic               own_q, own_d;
  logic               last_q, last_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               vld_q, lst_q, fmt_q;
  logic [INPT_DW-1:0] d_q;
  logic [BW-1:0]      vb_q;
  logic [60:0]        byte_cnt_q;
  logic [15:0]        cnt0_q, cnt1_q;

  logic               sel_vld, sel_lst, acc, grant, done, tmo_hit, therm, fmt_bad;
  logic [INPT_DW-1:0] sel_d;
  logic [BW-1:0]      sel_vb, inv_vb, inv_p1;
  logic [7:0]         pc;

  assign sel_vld = own_q ? req1_vld_i      : req0_vld_i;
  assign sel_d   = own_q ? req1_d_i        : req0_d_i;
  assign sel_vb  = own_q ? req1_vld_byte_i : req0_vld_byte_i;
  assign sel_lst = own_q ? req1_lst_i      : req0_lst_i;
  assign acc     = (state_q == XFER) && sel_vld;

  // Thermometer from MSB <=> the inverted mask is a run of low-order ones.
  assign inv_vb  = ~sel_vb;
  assign inv_p1  = inv_vb + 1'b1;
  assign therm   = (sel_vb != '0) && ((inv_vb & inv_p1) == '0);
  assign fmt_bad = sel_lst ? !therm : (sel_vb != '1);
  assign tmo_hit = (state_q == DRAIN) && (tmo_q == '0) && !pad_otpt_lst_i;

  always_comb begin
    pc = '0;
    for (int i = 0; i < BW; i++) pc = pc + 8'(sel_vb[i]);
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    grant   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_vld_i || req1_vld_i) begin
          grant   = 1'b1;
          state_d = XFER;
          own_d   = (req0_vld_i && req1_vld_i) ? ~last_q : req1_vld_i;
        end
      end
      XFER: begin
        if (acc && sel_lst) begin
          state_d = DRAIN;
          tmo_d   = TW'(DRAIN_TMO - 1);
        end
      end
      DRAIN: begin
        if (pad_otpt_lst_i) begin
          done    = 1'b1;
          last_d  = own_q;
          state_d = IDLE;
        end else if (tmo_q == '0) begin
          last_d  = own_q;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to 1 so that a simultaneous first request favours req0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= 1'b0;
      d_q        <= '0;
      vb_q       <= '0;
      lst_q      <= 1'b0;
      fmt_q      <= 1'b0;
      byte_cnt_q <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      vld_q <= acc;
      fmt_q <= acc && fmt_bad;
      if (acc) begin
        d_q        <= sel_d;
        vb_q       <= sel_vb;
        lst_q      <= sel_lst;
        byte_cnt_q <= byte_cnt_q + 61'(pc);
      end else begin
        lst_q <= 1'b0;
      end
      if (grant) byte_cnt_q <= '0;
      if (done && own_q)  cnt1_q <= cnt1_q + 1'b1;
      if (done && !own_q) cnt0_q <= cnt0_q + 1'b1;
    end
  end

  assign req0_rdy_o          = (state_q == XFER) && !own_q;
  assign req1_rdy_o          = (state_q == XFER) && own_q;
  assign msg_inpt_vld_o      = vld_q;
  assign msg_inpt_d_o        = d_q;
  assign msg_inpt_vld_byte_o = vb_q;
  assign msg_inpt_lst_o      = lst_q;
  assign own_id_o            = own_q;
  assign busy_o              = (state_q != IDLE);
  assign msg_byte_cnt_o      = byte_cnt_q;
  assign msg_cnt0_o          = cnt0_q;
  assign msg_cnt1_o          = cnt1_q;
  assign err_fmt_o           = fmt_q;
  assign err_tmo_o           = tmo_hit;

endmodule

// File: tb/tb_sm3_msg_arb.sv
// Directed bench for sm3_msg_arb: forwarded beats are checked against a scoreboard queue filled
// at stimulus time; counters, grant order, format errors, timeout and reset checked inline.
module tb_sm3_msg_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_vld, req0_lst, req1_vld, req1_lst, pad_lst;
  logic [31:0] req0_d, req1_d;
  logic [3:0]  req0_vb, req1_vb;
  logic        req0_rdy_o, req1_rdy_o, msg_inpt_vld_o, msg_inpt_lst_o;
  logic [31:0] msg_inpt_d_o;
  logic [3:0]  msg_inpt_vld_byte_o;
  logic        own_id_o, busy_o, err_fmt_o, err_tmo_o;
  logic [60:0] msg_byte_cnt_o;
  logic [15:0] msg_cnt0_o, msg_cnt1_o;

  always #5 clk = ~clk;

  sm3_msg_arb #(.INPT_DW(32), .DRAIN_TMO(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_vld_i(req0_vld), .req0_d_i(req0_d), .req0_vld_byte_i(req0_vb), .req0_lst_i(req0_lst),
    .req0_rdy_o(req0_rdy_o),
    .req1_vld_i(req1_vld), .req1_d_i(req1_d), .req1_vld_byte_i(req1_vb), .req1_lst_i(req1_lst),
    .req1_rdy_o(req1_rdy_o),
    .msg_inpt_vld_o(msg_inpt_vld_o), .msg_inpt_d_o(msg_inpt_d_o),
    .msg_inpt_vld_byte_o(msg_inpt_vld_byte_o), .msg_inpt_lst_o(msg_inpt_lst_o),
    .pad_otpt_lst_i(pad_lst), .own_id_o(own_id_o), .busy_o(busy_o),
    .msg_byte_cnt_o(msg_byte_cnt_o), .msg_cnt0_o(msg_cnt0_o), .msg_cnt1_o(msg_cnt1_o),
    .err_fmt_o(err_fmt_o), .err_tmo_o(err_tmo_o)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  vb;
    logic        lst;
    logic        err;
  } beat_t;

  beat_t       exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_bytes;
  logic [15:0] exp_cnt0, exp_cnt1;
  logic        prev_acc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic fmt_bad(input logic [3:0] vb, input logic lst);
    if (lst) return !(vb == 4'b1000 || vb == 4'b1100 || vb == 4'b1110 || vb == 4'b1111);
    return vb != 4'b1111;
  endfunction

  // Output monitor: every forwarded beat must match the queue head and follow an accept by 1 cycle.
  always @(negedge clk) begin
    beat_t e;
    #1;
    if (!rst_n) begin
      prev_acc = 1'b0;
    end else begin
      chk("fwd_lag", 64'(msg_inpt_vld_o), 64'(prev_acc));
      if (msg_inpt_vld_o) begin
        if (exp_q.size() == 0) begin
          chk("fwd_unexpected", 64'(msg_inpt_vld_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("fwd_d",   64'(msg_inpt_d_o),        64'(e.d));
          chk("fwd_vb",  64'(msg_inpt_vld_byte_o), 64'(e.vb));
          chk("fwd_lst", 64'(msg_inpt_lst_o),      64'(e.lst));
          chk("err_fmt", 64'(err_fmt_o),           64'(e.err));
        end
      end else begin
        chk("lst_idle", 64'(msg_inpt_lst_o), 64'd0);
        chk("fmt_idle", 64'(err_fmt_o),      64'd0);
      end
      prev_acc = (req0_vld && req0_rdy_o) || (req1_vld && req1_rdy_o);
    end
  end

  task automatic drive(input bit id, input logic v, input logic [31:0] d, input logic [3:0] vb,
                       input logic l);
    if (id) begin req1_vld = v; req1_d = d; req1_vb = vb; req1_lst = l; end
    else    begin req0_vld = v; req0_d = d; req0_vb = vb; req0_lst = l; end
  endtask

  task automatic send_beat(input bit id, input logic [31:0] d, input logic [3:0] vb, input logic l);
    int t = 0;
    drive(id, 1'b1, d, vb, l);
    while (!(id ? req1_rdy_o : req0_rdy_o) && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    assert (t < 40) else begin
      n_err++;
      $error("FAIL rdy_wait: observed no rdy after %0d cycles expected rdy for req%0d", t, id);
    end
    if (t < 40) begin
      chk("own_id", 64'(own_id_o), 64'(id));
      exp_q.push_back('{d: d, vb: vb, lst: l, err: fmt_bad(vb, l)});
      @(negedge clk);
    end
    drive(id, 1'b0, d, vb, 1'b0);
  endtask

  task automatic send_msg(input bit id, input int n, input logic [3:0] last_vb,
                          input logic [3:0] mid_vb);
    logic [3:0] vb;
    exp_bytes = '0;
    for (int i = 0; i < n; i++) begin
      vb = (i == n - 1) ? last_vb : mid_vb;
      exp_bytes = exp_bytes + 64'($countones(vb));
      send_beat(id, $urandom(), vb, i == n - 1);
    end
  endtask

  // Called in the first DRAIN cycle; raises pad lst after dly more cycles (dly <= 15).
  task automatic drain(input bit id, input int dly);
    for (int k = 0; k < dly; k++) begin
      chk("drain_busy", 64'(busy_o), 64'd1);
      @(negedge clk);
    end
    pad_lst = 1'b1;
    #1 chk("tmo_none", 64'(err_tmo_o), 64'd0);
    @(negedge clk);
    pad_lst = 1'b0;
    if (id) exp_cnt1++; else exp_cnt0++;
    chk("idle_busy", 64'(busy_o),         64'd0);
    chk("byte_cnt",  64'(msg_byte_cnt_o), exp_bytes);
    chk("msg_cnt0",  64'(msg_cnt0_o),     64'(exp_cnt0));
    chk("msg_cnt1",  64'(msg_cnt1_o),     64'(exp_cnt1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rdy0"}, 64'(req0_rdy_o),          64'd0);
    chk({tag, "_rdy1"}, 64'(req1_rdy_o),          64'd0);
    chk({tag, "_vld"},  64'(msg_inpt_vld_o),      64'd0);
    chk({tag, "_d"},    64'(msg_inpt_d_o),        64'd0);
    chk({tag, "_vb"},   64'(msg_inpt_vld_byte_o), 64'd0);
    chk({tag, "_lst"},  64'(msg_inpt_lst_o),      64'd0);
    chk({tag, "_own"},  64'(own_id_o),            64'd0);
    chk({tag, "_busy"}, 64'(busy_o),              64'd0);
    chk({tag, "_bcnt"}, 64'(msg_byte_cnt_o),      64'd0);
    chk({tag, "_cnt0"}, 64'(msg_cnt0_o),          64'd0);
    chk({tag, "_cnt1"}, 64'(msg_cnt1_o),          64'd0);
    chk({tag, "_efmt"}, 64'(err_fmt_o),           64'd0);
    chk({tag, "_etmo"}, 64'(err_tmo_o),           64'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1 check_all_zero("rst");
    exp_q.delete();
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] lvb, mvb;
    bit         rid;
    rst_n = 1'b0; pad_lst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    exp_cnt0 = '0; exp_cnt1 = '0; exp_bytes = '0;
    repeat (2) @(negedge clk);
    apply_reset();

    // Single 3-beat req0 message, last beat 1100 -> 10 bytes.
    send_msg(1'b0, 3, 4'b1100, 4'b1111);
    chk("bytes_10", exp_bytes, 64'd10);
    drain(1'b0, 2);

    // Both requesters valid in the same cycle right after reset: req0 first.
    @(negedge clk);
    apply_reset();
    drive(1'b1, 1'b1, 32'hA5A5_0001, 4'b1111, 1'b1);
    send_msg(1'b0, 1, 4'b1111, 4'b1111);
    drain(1'b0, 0);
    send_msg(1'b1, 1, 4'b1111, 4'b1111);
    drain(1'b1, 1);

    // Byte-enable format violations.
    @(negedge clk);
    send_msg(1'b0, 3, 4'b1010, 4'b1110);
    drain(1'b0, 3);
    @(negedge clk);
    send_msg(1'b1, 2, 4'b0000, 4'b1111);
    drain(1'b1, 0);
    @(negedge clk);
    send_msg(1'b0, 1, 4'b1000, 4'b1111);
    drain(1'b0, 1);

    // Drain timeout at the 16th DRAIN cycle, count unchanged.
    @(negedge clk);
    send_msg(1'b0, 2, 4'b1111, 4'b1111);
    for (int k = 1; k < 16; k++) begin
      #1 chk("tmo_early", 64'(err_tmo_o), 64'd0);
      @(negedge clk);
    end
    #1 chk("tmo_pulse", 64'(err_tmo_o), 64'd1);
    chk("tmo_busy", 64'(busy_o), 64'd1);
    @(negedge clk);
    chk("tmo_idle",  64'(busy_o),     64'd0);
    chk("tmo_clear", 64'(err_tmo_o),  64'd0);
    chk("tmo_cnt0",  64'(msg_cnt0_o), 64'(exp_cnt0));

    // pad lst on the last possible DRAIN cycle wins over the timeout.
    send_msg(1'b1, 1, 4'b1111, 4'b1111);
    drain(1'b1, 15);

    // Reset mid-XFER with req1 pending; req1 served after release.
    @(negedge clk);
    send_beat(1'b0, 32'h1234_5678, 4'b1111, 1'b0);
    drive(1'b1, 1'b1, 32'hCAFE_0000, 4'b1111, 1'b1);
    apply_reset();
    send_msg(1'b1, 2, 4'b1110, 4'b1111);
    drain(1'b1, 0);

    // Random traffic.
    for (int m = 0; m < 40; m++) begin
      @(negedge clk);
      rid = 1'($urandom_range(0, 1));
      lvb = 4'($urandom_range(0, 15));
      mvb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111;
      send_msg(rid, $urandom_range(1, 4), lvb, mvb);
      drain(rid, $urandom_range(0, 15));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
